// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if : pipeline-side view of the hazard/forwarding controller
// Revision 1.0
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
);
  logic [RA_W-1:0]  id_rs, id_rt;
  logic             id_uses_rt;
  logic [RA_W-1:0]  ex_rs, ex_rt;
  logic             ex_mem_read;
  logic             ex_mul;
  logic             mem_wr;
  logic [RA_W-1:0]  mem_rd;
  logic             wb_wr;
  logic [RA_W-1:0]  wb_rd;
  logic             br_taken;

  logic             pc_write, ifid_write, idex_write;
  logic             idex_bubble, exmem_bubble;
  logic             ifid_flush, idex_flush, exmem_flush;
  logic [1:0]       fwd_a, fwd_b;
  logic             mul_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_mem_read, ex_mul,
           mem_wr, mem_rd, wb_wr, wb_rd, br_taken,
    input  pc_write, ifid_write, idex_write, idex_bubble, exmem_bubble,
           ifid_flush, idex_flush, exmem_flush, fwd_a, fwd_b, mul_busy, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_mem_read, ex_mul,
           mem_wr, mem_rd, wb_wr, wb_rd, br_taken,
    output pc_write, ifid_write, idex_write, idex_bubble, exmem_bubble,
           ifid_flush, idex_flush, exmem_flush, fwd_a, fwd_b, mul_busy, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl : forwarding, load-use/multiply stall and branch flush control
// Revision 1.0
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int RA_W     = 5,
  parameter int MUL_LAT  = 4,
  parameter int BR_FLUSH = 3,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  hz
);

  localparam int              MC_W     = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [MC_W-1:0] MC_LAST  = MC_W'(MUL_LAT - 1);
  localparam logic            FL_IDEX  = (BR_FLUSH >= 2);
  localparam logic            FL_EXMEM = (BR_FLUSH >= 3);

  typedef enum logic [0:0] {RUN = 1'b0, MUL = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [MC_W-1:0]  mcnt, mcnt_nxt;
  logic [CNT_W-1:0] stall_q;

  logic       luh;
  logic [1:0] fwd_a, fwd_b;
  logic       pc_w, ifid_w, idex_w, idex_bub, exmem_bub;
  logic       fl_ifid, fl_idex, fl_exmem;

  function automatic logic [1:0] fwd_sel(
    input logic [RA_W-1:0] src,
    input logic            m_wr,
    input logic [RA_W-1:0] m_rd,
    input logic            w_wr,
    input logic [RA_W-1:0] w_rd
  );
    // EX/MEM holds the younger result, so it has priority over MEM/WB
    if (m_wr && (m_rd != '0) && (m_rd == src))      return 2'b01;
    else if (w_wr && (w_rd != '0) && (w_rd == src)) return 2'b10;
    else                                            return 2'b00;
  endfunction

  always_comb begin
    fwd_a = fwd_sel(hz.ex_rs, hz.mem_wr, hz.mem_rd, hz.wb_wr, hz.wb_rd);
    fwd_b = fwd_sel(hz.ex_rt, hz.mem_wr, hz.mem_rd, hz.wb_wr, hz.wb_rd);
    luh   = hz.ex_mem_read && (hz.ex_rt != '0) &&
            ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      mcnt  <= '0;
    end else begin
      state <= state_nxt;
      mcnt  <= mcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mcnt_nxt  = mcnt;
    pc_w      = 1'b1;
    ifid_w    = 1'b1;
    idex_w    = 1'b1;
    idex_bub  = 1'b0;
    exmem_bub = 1'b0;
    fl_ifid   = 1'b0;
    fl_idex   = 1'b0;
    fl_exmem  = 1'b0;
    case (state)
      RUN: begin
        if (hz.br_taken) begin
          fl_ifid  = 1'b1;
          fl_idex  = FL_IDEX;
          fl_exmem = FL_EXMEM;
        end else if (hz.ex_mul) begin
          pc_w      = 1'b0;
          ifid_w    = 1'b0;
          idex_w    = 1'b0;
          exmem_bub = 1'b1;
          mcnt_nxt  = MC_W'(1);
          state_nxt = MUL;
        end else if (luh) begin
          pc_w     = 1'b0;
          ifid_w   = 1'b0;
          idex_bub = 1'b1;
        end
      end
      MUL: begin
        // ex_mul is not looked at here: the multiply itself is still sitting in EX
        if (hz.br_taken) begin
          fl_ifid   = 1'b1;
          fl_idex   = FL_IDEX;
          fl_exmem  = FL_EXMEM;
          mcnt_nxt  = '0;
          state_nxt = RUN;
        end else if (mcnt == MC_LAST) begin
          if (luh) begin
            pc_w     = 1'b0;
            ifid_w   = 1'b0;
            idex_bub = 1'b1;
          end
          mcnt_nxt  = '0;
          state_nxt = RUN;
        end else begin
          pc_w      = 1'b0;
          ifid_w    = 1'b0;
          idex_w    = 1'b0;
          exmem_bub = 1'b1;
          mcnt_nxt  = mcnt + 1'b1;
        end
      end
      default: begin
        mcnt_nxt  = '0;
        state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_q <= '0;
    else if (!pc_w && !hz.br_taken && (stall_q != {CNT_W{1'b1}}))
      stall_q <= stall_q + 1'b1;
  end

  // Outputs fall back to a free-running pipeline while reset is held
  assign hz.pc_write     = !rst || pc_w;
  assign hz.ifid_write   = !rst || ifid_w;
  assign hz.idex_write   = !rst || idex_w;
  assign hz.idex_bubble  = rst && idex_bub;
  assign hz.exmem_bubble = rst && exmem_bub;
  assign hz.ifid_flush   = rst && fl_ifid;
  assign hz.idex_flush   = rst && fl_idex;
  assign hz.exmem_flush  = rst && fl_exmem;
  assign hz.fwd_a        = rst ? fwd_a : 2'b00;
  assign hz.fwd_b        = rst ? fwd_b : 2'b00;
  assign hz.mul_busy     = rst && (state == MUL);
  assign hz.stall_cnt    = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl : vector table plus multi-cycle sequences for pipe_hazard_ctrl
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic [4:0] id_rs, id_rt;
    logic       uses_rt;
    logic [4:0] ex_rs, ex_rt;
    logic       mem_read, mul, mem_wr;
    logic [4:0] mem_rd;
    logic       wb_wr;
    logic [4:0] wb_rd;
    logic       br;
  } in_t;

  typedef struct {
    in_t        in;
    logic [1:0] fa, fb;
    logic       stall;
  } vec_t;

  typedef struct {
    string       nm;
    logic [12:0] e;
  } sb_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  in_t   cur = '0;
  int    n_tests = 0;
  int    n_fail  = 0;
  int    exp_cnt = 0;
  sb_t   sb[$];
  vec_t  tbl[13];

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.RA_W(5), .CNT_W(16)) u_if  ();
  pipe_hazard_ctrl_if #(.RA_W(5), .CNT_W(16)) u_if1 ();
  pipe_hazard_ctrl_if #(.RA_W(5), .CNT_W(2))  u_if2 ();

  assign u_if.id_rs = cur.id_rs;         assign u_if.id_rt = cur.id_rt;     assign u_if.id_uses_rt = cur.uses_rt;
  assign u_if.ex_rs = cur.ex_rs;         assign u_if.ex_rt = cur.ex_rt;     assign u_if.ex_mem_read = cur.mem_read;
  assign u_if.ex_mul = cur.mul;          assign u_if.mem_wr = cur.mem_wr;   assign u_if.mem_rd = cur.mem_rd;
  assign u_if.wb_wr = cur.wb_wr;         assign u_if.wb_rd = cur.wb_rd;     assign u_if.br_taken = cur.br;
  assign u_if1.id_rs = cur.id_rs;        assign u_if1.id_rt = cur.id_rt;    assign u_if1.id_uses_rt = cur.uses_rt;
  assign u_if1.ex_rs = cur.ex_rs;        assign u_if1.ex_rt = cur.ex_rt;    assign u_if1.ex_mem_read = cur.mem_read;
  assign u_if1.ex_mul = cur.mul;         assign u_if1.mem_wr = cur.mem_wr;  assign u_if1.mem_rd = cur.mem_rd;
  assign u_if1.wb_wr = cur.wb_wr;        assign u_if1.wb_rd = cur.wb_rd;    assign u_if1.br_taken = cur.br;
  assign u_if2.id_rs = cur.id_rs;        assign u_if2.id_rt = cur.id_rt;    assign u_if2.id_uses_rt = cur.uses_rt;
  assign u_if2.ex_rs = cur.ex_rs;        assign u_if2.ex_rt = cur.ex_rt;    assign u_if2.ex_mem_read = cur.mem_read;
  assign u_if2.ex_mul = cur.mul;         assign u_if2.mem_wr = cur.mem_wr;  assign u_if2.mem_rd = cur.mem_rd;
  assign u_if2.wb_wr = cur.wb_wr;        assign u_if2.wb_rd = cur.wb_rd;    assign u_if2.br_taken = cur.br;

  pipe_hazard_ctrl #(.RA_W(5), .MUL_LAT(4), .BR_FLUSH(3), .CNT_W(16)) u_dut  (.clk(clk), .rst(rst), .hz(u_if));
  pipe_hazard_ctrl #(.RA_W(5), .MUL_LAT(4), .BR_FLUSH(1), .CNT_W(16)) u_dut1 (.clk(clk), .rst(rst), .hz(u_if1));
  pipe_hazard_ctrl #(.RA_W(5), .MUL_LAT(4), .BR_FLUSH(3), .CNT_W(2))  u_dut2 (.clk(clk), .rst(rst), .hz(u_if2));

  // {fwd_a, fwd_b, pc, ifid, idex, idex_bub, exmem_bub, flush[ifid,idex,exmem], mul_busy}
  logic [12:0] act;
  assign act = {u_if.fwd_a, u_if.fwd_b, u_if.pc_write, u_if.ifid_write, u_if.idex_write,
                u_if.idex_bubble, u_if.exmem_bubble, u_if.ifid_flush, u_if.idex_flush,
                u_if.exmem_flush, u_if.mul_busy};

  function automatic logic [12:0] mk_exp(input logic [1:0] fa, input logic [1:0] fb,
                                         input logic pc, input logic ifid, input logic idex,
                                         input logic idb, input logic exb,
                                         input logic [2:0] fl, input logic busy);
    return {fa, fb, pc, ifid, idex, idb, exb, fl, busy};
  endfunction

  function automatic logic [12:0] e_norm(input logic busy);
    return mk_exp(2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, busy);
  endfunction
  function automatic logic [12:0] e_mstall(input logic busy);
    return mk_exp(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, busy);
  endfunction
  function automatic logic [12:0] e_flush(input logic busy);
    return mk_exp(2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b111, busy);
  endfunction

  function automatic in_t vin(input int id_rs, input int id_rt, input logic ut, input int ex_rs,
                              input int ex_rt, input logic mr, input logic mw, input int mrd,
                              input logic ww, input int wrd, input logic br);
    in_t v;
    v = '0;
    v.id_rs = 5'(id_rs); v.id_rt = 5'(id_rt); v.uses_rt = ut;
    v.ex_rs = 5'(ex_rs); v.ex_rt = 5'(ex_rt); v.mem_read = mr;
    v.mem_wr = mw; v.mem_rd = 5'(mrd); v.wb_wr = ww; v.wb_rd = 5'(wrd); v.br = br;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, actual, expected);
    end
  endtask

  task automatic pop_check();
    sb_t it;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries, expected 1");
    end else begin
      it = sb.pop_front();
      check(it.nm, 32'(act), 32'(it.e));
    end
  endtask

  task automatic step(input string nm, input in_t v, input logic [12:0] e);
    @(posedge clk);
    #1;
    cur = v;
    sb.push_back('{nm, e});
    @(negedge clk);
    pop_check();
    check({nm, "_cnt"}, 32'(u_if.stall_cnt), 32'(exp_cnt));
    check({nm, "_sat"}, 32'(u_if2.stall_cnt), 32'((exp_cnt > 3) ? 3 : exp_cnt));
    if (!e[8] && !v.br) exp_cnt++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t z, m, bm;
    z  = '0;
    m  = '0; m.mul = 1'b1;
    bm = m;  bm.br = 1'b1;

    tbl[0]  = '{vin(0,0,0, 3,0, 0, 1,3, 1,3, 0), 2'b01, 2'b00, 1'b0};
    tbl[1]  = '{vin(0,0,0, 3,0, 0, 0,3, 1,3, 0), 2'b10, 2'b00, 1'b0};
    tbl[2]  = '{vin(0,0,0, 3,0, 0, 1,0, 1,0, 0), 2'b00, 2'b00, 1'b0};
    tbl[3]  = '{vin(0,0,0, 3,7, 0, 1,7, 1,3, 0), 2'b10, 2'b01, 1'b0};
    tbl[4]  = '{vin(0,0,0, 9,4, 0, 1,9, 1,4, 0), 2'b01, 2'b10, 1'b0};
    tbl[5]  = '{vin(0,0,0, 9,4, 0, 1,9, 0,4, 0), 2'b01, 2'b00, 1'b0};
    tbl[6]  = '{vin(5,0,0, 0,5, 1, 0,0, 0,0, 0), 2'b00, 2'b00, 1'b1};
    tbl[7]  = '{vin(1,5,0, 0,5, 1, 0,0, 0,0, 0), 2'b00, 2'b00, 1'b0};
    tbl[8]  = '{vin(1,5,1, 0,5, 1, 0,0, 0,0, 0), 2'b00, 2'b00, 1'b1};
    tbl[9]  = '{vin(0,0,1, 0,0, 1, 0,0, 0,0, 0), 2'b00, 2'b00, 1'b0};
    tbl[10] = '{vin(5,0,0, 0,5, 1, 0,0, 0,0, 1), 2'b00, 2'b00, 1'b0};
    tbl[11] = '{vin(5,0,0, 0,5, 0, 0,0, 0,0, 0), 2'b00, 2'b00, 1'b0};
    tbl[12] = '{vin(0,0,0, 6,6, 0, 0,6, 0,6, 0), 2'b00, 2'b00, 1'b0};

    // Reset with hostile inputs: everything must sit at the reset values
    cur = vin(5,0,0, 3,5, 1, 1,3, 1,3, 1);
    cur.mul = 1'b1;
    #2;
    sb.push_back('{"reset_out", e_norm(1'b0)});
    pop_check();
    check("reset_cnt", 32'(u_if.stall_cnt), 32'd0);
    @(negedge clk);
    cur = z;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      step($sformatf("vec%0d", i), tbl[i].in,
           mk_exp(tbl[i].fa, tbl[i].fb, !tbl[i].stall, !tbl[i].stall, 1'b1, tbl[i].stall,
                  1'b0, tbl[i].in.br ? 3'b111 : 3'b000, 1'b0));
    end

    // Multiply occupies EX for four cycles: three stalls, then release
    step("mul_t0",  m, e_mstall(1'b0));
    step("mul_t1",  m, e_mstall(1'b1));
    step("mul_t2",  m, e_mstall(1'b1));
    step("mul_rel", m, e_norm(1'b1));
    step("mul_aft", z, e_norm(1'b0));
    check("mul_cost", 32'(u_if.stall_cnt), 32'd5);

    // Branch wins over a multiply arriving in the same cycle
    step("brmul", bm, e_flush(1'b0));
    check("br1_flush", 32'({u_if1.ifid_flush, u_if1.idex_flush, u_if1.exmem_flush}), 32'b100);
    step("brmul_aft", z, e_norm(1'b0));

    // Branch in the second multiply cycle abandons the multiply
    step("mbr_t0",  m,  e_mstall(1'b0));
    step("mbr_t1",  m,  e_mstall(1'b1));
    step("mbr_br",  bm, e_flush(1'b1));
    step("mbr_aft", z,  e_norm(1'b0));
    check("sat_cnt", 32'(u_if2.stall_cnt), 32'd3);

    // Asynchronous reset in the middle of a multiply
    step("rm_t0", m, e_mstall(1'b0));
    step("rm_t1", m, e_mstall(1'b1));
    #2;
    rst = 1'b0;
    exp_cnt = 0;
    #1;
    sb.push_back('{"rm_rst", e_norm(1'b0)});
    pop_check();
    check("rm_rst_cnt", 32'(u_if.stall_cnt), 32'd0);
    check("rm_rst_sat", 32'(u_if2.stall_cnt), 32'd0);
    @(posedge clk);
    @(negedge clk);
    sb.push_back('{"rm_hold", e_norm(1'b0)});
    pop_check();
    rst = 1'b1;
    #1;
    sb.push_back('{"rm_first_run", e_mstall(1'b0)});
    pop_check();
    @(negedge clk);
    sb.push_back('{"rm_mul", e_mstall(1'b1)});
    pop_check();
    check("rm_cnt", 32'(u_if.stall_cnt), 32'd1);
    cur = z;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
